soc_console_bridge: RTL and testbench
=====================================

Name: soc_console_bridge

Overview:
- Synthesisable successor to the simulation console harness: collects byte-output strobes from NUM_CH sources (cores or peripherals) into a FIFO and serialises them on an 8N1 UART.
- Also owns the SoC's post-reset hold (core release after RESET_HOLD cycles) and trap capture.
- Raises done once a trap is latched and all buffered output has been transmitted.
- Sits at SoC top between the core(s) and the board UART pin.

Parameters:
- NUM_CH, 2, number of byte-output channels (1..8).
- FIFO_DEPTH, 16, FIFO entries; power of 2, >=2.
- CLKS_PER_BIT, 868, clk cycles per UART bit (>=2).
- RESET_HOLD, 100, cycles after resetn deassertion before core_resetn_o rises (>=1).
- TAG_EN, 1, when 1 a channel tag byte is emitted on channel change.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- ch_byte  in  8*NUM_CH  byte per channel; channel i = bits [8i+7:8i].
- ch_byte_en  in  NUM_CH  single-cycle write strobe per channel.
- trap_i  in  1  trap from core(s).
- core_resetn_o  out  1  active-low reset to cores, registered.
- uart_tx  out  1  serial output, idle high.
- fifo_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky: at least one byte dropped.
- trap_latched  out  1  sticky trap flag.
- done  out  1  trap_latched & FIFO empty & TX idle.

Behaviour:
- Reset, while resetn=0: core_resetn_o=0, uart_tx=1, fifo_level=0, overflow=0, trap_latched=0, done=0; hold counter, FIFO pointers and TX FSM cleared; last_ch set to an invalid value so the first byte is always tagged.
- Reset hold: counter increments each cycle with resetn=1. When count reaches RESET_HOLD, core_resetn_o goes 1 on the next edge and stays 1. resetn low at any time re-enters reset, including mid-transmission: the frame is abandoned and uart_tx returns to 1 immediately.
- Capture: ch_byte_en is ignored while core_resetn_o=0 or trap_latched=1.
  - At most one push per cycle. If several strobes are set, the lowest index wins.
  - Losing strobes are dropped and set overflow.
  - A push when the FIFO is full is dropped, sets overflow, and leaves FIFO contents unchanged.
  - Each entry stores {ch_index, byte}.
- FIFO: synchronous, registered pointers wrapping modulo FIFO_DEPTH. Push and pop in the same cycle when full or non-empty leaves fifo_level unchanged. A push is visible in fifo_level on the next cycle.
- TX FSM, states IDLE, START, DATA, STOP, each bit held CLKS_PER_BIT cycles:
  - IDLE: if FIFO is non-empty, pop the head (one cycle) and load the shift register.
  - If TAG_EN=1 and the entry's ch != last_ch, first send the tag byte 8'h80|ch as a full frame, then the data byte. last_ch is updated when the tag is sent.
  - START: uart_tx=0. DATA: 8 bits, LSB first. STOP: uart_tx=1, then return to IDLE.
  - Back-to-back frames are separated only by the pop cycle. Minimum frame period = 10*CLKS_PER_BIT+1 cycles.
  - With TAG_EN=0 no tags are sent and last_ch is unused.
- Trap: trap_i sampled only when core_resetn_o=1. Once seen, trap_latched=1 on the next edge, sticky until reset. A strobe in the same cycle as trap_i is still accepted.
- done: registered; asserts the cycle after trap_latched=1, fifo_level=0 and FSM in IDLE all hold. Sticky until reset.
- uart_tx is registered, with no combinational path from inputs.

Test Plan:
- Reset hold (RESET_HOLD=100): release resetn at cycle 0 -> core_resetn_o rises exactly at edge 101; a strobe at cycle 50 is ignored (fifo_level stays 0).
- Single byte (CLKS_PER_BIT=4, TAG_EN=0): ch0 writes 8'h41 -> uart_tx shows 0,1,0,0,0,0,0,1,0,1 at 4 cycles per bit.
- Tagging (TAG_EN=1, NUM_CH=2): ch1 'A', ch1 'B', ch0 'C' -> frames 0x81,0x41,0x42,0x80,0x43.
- Simultaneous and overflow (FIFO_DEPTH=4): ch0 and ch1 strobe together -> only ch0 byte queued, overflow=1. Then 6 back-to-back ch0 writes during TX -> fifo_level saturates at 4, excess dropped.
- Trap drain: queue 3 bytes then pulse trap_i -> trap_latched next cycle; later strobes ignored; done rises one cycle after the last stop bit.
- Reset mid-frame: drive resetn=0 during DATA -> next edge uart_tx=1, fifo_level=0, core_resetn_o=0, flags cleared.

Source files
------------

// File: rtl/soc_console_bridge.sv
// soc_console_bridge: multi-channel console FIFO serialised on an 8N1 UART, plus core reset hold, trap latch and done.
module soc_console_bridge #(
   parameter int NUM_CH       = 2,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 868,
   parameter int RESET_HOLD   = 100,
   parameter int TAG_EN       = 1
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [8*NUM_CH-1:0]              ch_byte,
   input  logic [NUM_CH-1:0]                ch_byte_en,
   input  logic                             trap_i,
   output logic                             core_resetn_o,
   output logic                             uart_tx,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             overflow,
   output logic                             trap_latched,
   output logic                             done
);
   localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = $clog2(FIFO_DEPTH + 1);
   localparam int HW  = $clog2(RESET_HOLD + 1);
   localparam int CW  = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [HW-1:0]  hold_q, hold_d;
   logic           core_q, core_d, trap_q, trap_d, ovf_q, ovf_d, done_q, done_d, tx_q, tx_d;
   logic [CHW+7:0] mem_q [FIFO_DEPTH];
   logic [CHW+7:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0]  level_q, level_d;
   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     sh_q, sh_d, data_q, data_d;
   logic           pend_q, pend_d, lastv_q, lastv_d;
   logic [CHW-1:0] last_q, last_d;
   logic [NUM_CH-1:0] en;
   logic [CHW-1:0] sel_ch, head_ch;
   logic [7:0]     sel_byte, head_byte;
   logic           push, wr, pop, full, empty, bit_end;

   assign {head_ch, head_byte} = mem_q[rp_q];
   assign full  = level_q == LW'(FIFO_DEPTH);
   assign empty = level_q == '0;

   always_comb begin
      en = ch_byte_en & {NUM_CH{core_q & ~trap_q}};
      sel_ch = '0;
      sel_byte = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (en[i]) begin
            sel_ch = CHW'(i);
            sel_byte = ch_byte[8*i +: 8];
         end
      end
      push = |en;
      wr = push & (~full | pop);
      mem_d = mem_q;
      if (wr) mem_d[wp_q] = {sel_ch, sel_byte};
      wp_d = wp_q + AW'(wr);
      rp_d = rp_q + AW'(pop);
      level_d = level_q + LW'(wr) - LW'(pop);
      ovf_d = ovf_q | (push & ~wr) | ((en & (en - NUM_CH'(1))) != '0);
      hold_d = hold_q == HW'(RESET_HOLD) ? hold_q : hold_q + HW'(1);
      core_d = core_q | (hold_q == HW'(RESET_HOLD));
      trap_d = trap_q | (core_q & trap_i);
      done_d = done_q | (trap_q & empty & (state_q == IDLE) & ~pend_q);
   end

   // A tag frame leaves the data byte pending; it goes out after one IDLE cycle like any other frame.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      bit_d = bit_q;
      sh_d = sh_q;
      data_d = data_q;
      pend_d = pend_q;
      last_d = last_q;
      lastv_d = lastv_q;
      pop = 1'b0;
      bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pend_q) begin
               state_d = START;
               sh_d = data_q;
               pend_d = 1'b0;
            end else if (!empty) begin
               pop = 1'b1;
               state_d = START;
               if (TAG_EN != 0 && (!lastv_q || head_ch != last_q)) begin
                  sh_d = 8'h80 | {{(8-CHW){1'b0}}, head_ch};
                  data_d = head_byte;
                  pend_d = 1'b1;
                  last_d = head_ch;
                  lastv_d = 1'b1;
               end else begin
                  sh_d = head_byte;
               end
            end
         end
         START: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            bit_d = '0;
            state_d = bit_end ? DATA : START;
         end
         DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            sh_d = bit_end ? sh_q >> 1 : sh_q;
            bit_d = bit_end ? bit_q + 3'd1 : bit_q;
            state_d = (bit_end && bit_q == 3'd7) ? STOP : DATA;
         end
         default: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            state_d = bit_end ? IDLE : STOP;
         end
      endcase
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hold_q <= '0;
         core_q <= 1'b0;
         trap_q <= 1'b0;
         ovf_q <= 1'b0;
         done_q <= 1'b0;
         tx_q <= 1'b1;
         wp_q <= '0;
         rp_q <= '0;
         level_q <= '0;
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         data_q <= '0;
         pend_q <= 1'b0;
         last_q <= '0;
         lastv_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         core_q <= core_d;
         trap_q <= trap_d;
         ovf_q <= ovf_d;
         done_q <= done_d;
         tx_q <= tx_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
         level_q <= level_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         data_q <= data_d;
         pend_q <= pend_d;
         last_q <= last_d;
         lastv_q <= lastv_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   assign core_resetn_o = core_q;
   assign uart_tx       = tx_q;
   assign fifo_level    = level_q;
   assign overflow      = ovf_q;
   assign trap_latched  = trap_q;
   assign done          = done_q;
endmodule

// File: tb/tb_soc_console_bridge.sv
// tb_soc_console_bridge: tagged and untagged bridges driven in parallel, UART output decoded and checked against a byte-stream model.
module tb_soc_console_bridge;
   localparam int CPB = 4;
   localparam int RH  = 100;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] ch_byte;
   logic [1:0]  ch_byte_en;
   logic        trap_i;
   logic        core0, core1, tx0, tx1, ovf0, ovf1, trp0, trp1, done0, done1;
   logic [2:0]  lvl0, lvl1;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   bit m_core, m_trap, m_ovf;
   int acc_ch[$];
   int acc_b[$];
   int rxq[2][$];
   int expq[2][$];
   logic       mon_busy [2];
   int         mon_cnt [2];
   logic [7:0] mon_byte [2];
   int         mon_t0 [2];

   soc_console_bridge #(.NUM_CH(2), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .RESET_HOLD(RH), .TAG_EN(1)) dut (
      .clk(clk), .resetn(resetn), .ch_byte(ch_byte), .ch_byte_en(ch_byte_en), .trap_i(trap_i),
      .core_resetn_o(core0), .uart_tx(tx0), .fifo_level(lvl0), .overflow(ovf0),
      .trap_latched(trp0), .done(done0));

   soc_console_bridge #(.NUM_CH(2), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .RESET_HOLD(RH), .TAG_EN(0)) dut_nt (
      .clk(clk), .resetn(resetn), .ch_byte(ch_byte), .ch_byte_en(ch_byte_en), .trap_i(trap_i),
      .core_resetn_o(core1), .uart_tx(tx1), .fifo_level(lvl1), .overflow(ovf1),
      .trap_latched(trp1), .done(done1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic txs(input int k);
      return k == 0 ? tx0 : tx1;
   endfunction

   // UART receiver: mid-bit sampling; a bad stop bit is flagged by adding 256 to the byte.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!resetn) mon_busy[k] <= 1'b0;
         else if (mon_busy[k] !== 1'b1) begin
            if (txs(k) === 1'b0) begin
               mon_busy[k] <= 1'b1;
               mon_cnt[k] <= 1;
               mon_t0[k] <= cyc;
            end
         end else begin
            mon_cnt[k] <= mon_cnt[k] + 1;
            if (mon_cnt[k] % CPB == CPB / 2 && mon_cnt[k] / CPB >= 1 && mon_cnt[k] / CPB <= 8)
               mon_byte[k][mon_cnt[k] / CPB - 1] <= txs(k);
            if (mon_cnt[k] == 9 * CPB + CPB / 2) begin
               rxq[k].push_back(txs(k) === 1'b1 ? int'(mon_byte[k]) : 256 + int'(mon_byte[k]));
               mon_busy[k] <= 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void build_exp();
      int last = -1;
      expq[0].delete();
      expq[1].delete();
      foreach (acc_b[i]) begin
         if (acc_ch[i] != last) begin
            expq[0].push_back(128 + acc_ch[i]);
            last = acc_ch[i];
         end
         expq[0].push_back(acc_b[i]);
         expq[1].push_back(acc_b[i]);
      end
   endfunction

   task automatic do_reset();
      resetn = 1'b0;
      ch_byte_en = '0;
      ch_byte = '0;
      trap_i = 1'b0;
      repeat (3) tick();
      m_core = 0;
      m_trap = 0;
      m_ovf = 0;
      acc_ch.delete();
      acc_b.delete();
      rxq[0].delete();
      rxq[1].delete();
   endtask

   task automatic release_hold();
      resetn = 1'b1;
      repeat (RH + 1) tick();
      m_core = 1;
   endtask

   task automatic strobe(input logic [1:0] en, input logic [7:0] b0, input logic [7:0] b1, input logic tr);
      ch_byte_en = en;
      ch_byte = {b1, b0};
      trap_i = tr;
      if (m_core && !m_trap && en != 2'b00) begin
         acc_ch.push_back(en[0] ? 0 : 1);
         acc_b.push_back(en[0] ? int'(b0) : int'(b1));
         if (en == 2'b11) m_ovf = 1;
      end
      if (tr && m_core) m_trap = 1;
      tick();
      ch_byte_en = '0;
      trap_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({core0, tx0, lvl0, ovf0, trp0, done0} !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL reset_state0: got %b want 01000000", {core0, tx0, lvl0, ovf0, trp0, done0});
      end
      n_cmp++;
      if ({core1, tx1, lvl1, ovf1, trp1, done1} !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL reset_state1: got %b want 01000000", {core1, tx1, lvl1, ovf1, trp1, done1});
      end
      resetn = 1'b1;
      for (int t = 1; t <= RH + 1; t++) begin
         ch_byte_en = (t == 50) ? 2'b11 : 2'b00;
         ch_byte = 16'h3344;
         trap_i = (t == 60);
         tick();
         n_cmp++;
         if (core0 !== (t > RH)) begin
            n_fail++;
            $display("FAIL hold_core edge %0d: got %b want %b", t, core0, t > RH);
         end
         if (t == 51) begin
            n_cmp++;
            if ({lvl0, ovf0, lvl1, ovf1} !== 8'h00) begin
               n_fail++;
               $display("FAIL hold_strobe_ignored: got lvl/ovf %b want 0", {lvl0, ovf0, lvl1, ovf1});
            end
         end
      end
      trap_i = 1'b0;
      ch_byte_en = '0;
      n_cmp++;
      if ({trp0, trp1, core1} !== 3'b001) begin
         n_fail++;
         $display("FAIL hold_trap_ignored: got trp0,trp1,core1=%b want 001", {trp0, trp1, core1});
      end
   endtask

   task automatic test_single();
      logic [9:0] pat = 10'b1010000010;
      do_reset();
      release_hold();
      strobe(2'b01, 8'h41, 8'h00, 1'b0);
      n_cmp++;
      if (lvl1 !== 3'd1) begin
         n_fail++;
         $display("FAIL single_level: got %0d want 1", lvl1);
      end
      tick();
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < CPB; c++) begin
            n_cmp++;
            if (tx1 !== pat[b]) begin
               n_fail++;
               $display("FAIL single_bit %0d cyc %0d: got %b want %b", b, c, tx1, pat[b]);
            end
            tick();
         end
      end
      repeat (60) tick();
      build_exp();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rxq[k].size() != expq[k].size()) begin
            n_fail++;
            $display("FAIL single_count[%0d]: got %0d frames want %0d", k, rxq[k].size(), expq[k].size());
         end
         for (int i = 0; i < expq[k].size(); i++) begin
            n_cmp++;
            if (i >= rxq[k].size() || rxq[k][i] != expq[k][i]) begin
               n_fail++;
               $display("FAIL single_frame[%0d][%0d]: got %0h want %0h", k, i, i < rxq[k].size() ? rxq[k][i] : -1, expq[k][i]);
            end
         end
      end
   endtask

   task automatic test_tagging();
      do_reset();
      release_hold();
      strobe(2'b10, 8'h00, 8'h41, 1'b0);
      strobe(2'b10, 8'h00, 8'h42, 1'b0);
      strobe(2'b01, 8'h43, 8'h00, 1'b0);
      repeat (260) tick();
      build_exp();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rxq[k].size() != expq[k].size()) begin
            n_fail++;
            $display("FAIL tag_count[%0d]: got %0d frames want %0d", k, rxq[k].size(), expq[k].size());
         end
         for (int i = 0; i < expq[k].size(); i++) begin
            n_cmp++;
            if (i >= rxq[k].size() || rxq[k][i] != expq[k][i]) begin
               n_fail++;
               $display("FAIL tag_frame[%0d][%0d]: got %0h want %0h", k, i, i < rxq[k].size() ? rxq[k][i] : -1, expq[k][i]);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      release_hold();
      strobe(2'b11, 8'($urandom), 8'($urandom), 1'b0);
      n_cmp++;
      if ({ovf0, ovf1, lvl0, lvl1} !== {2'b11, 3'd1, 3'd1}) begin
         n_fail++;
         $display("FAIL simul_ovf_level: got ovf=%b%b lvl=%0d,%0d want ovf=11 lvl=1,1", ovf0, ovf1, lvl0, lvl1);
      end
      repeat (120) tick();
      build_exp();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rxq[k].size() != expq[k].size()) begin
            n_fail++;
            $display("FAIL simul_count[%0d]: got %0d frames want %0d", k, rxq[k].size(), expq[k].size());
         end
         for (int i = 0; i < expq[k].size(); i++) begin
            n_cmp++;
            if (i >= rxq[k].size() || rxq[k][i] != expq[k][i]) begin
               n_fail++;
               $display("FAIL simul_frame[%0d][%0d]: got %0h want %0h", k, i, i < rxq[k].size() ? rxq[k][i] : -1, expq[k][i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      release_hold();
      strobe(2'b01, 8'h55, 8'h00, 1'b0);
      tick();
      for (int j = 1; j <= 6; j++) begin
         strobe(2'b01, 8'($urandom), 8'h00, 1'b0);
         n_cmp++;
         if ({lvl0, lvl1} !== {3'(j > 4 ? 4 : j), 3'(j > 4 ? 4 : j)}) begin
            n_fail++;
            $display("FAIL ovf_level write %0d: got %0d,%0d want %0d", j, lvl0, lvl1, j > 4 ? 4 : j);
         end
         n_cmp++;
         if ({ovf0, ovf1} !== {2{j > 4}}) begin
            n_fail++;
            $display("FAIL ovf_flag write %0d: got %b%b want %b", j, ovf0, ovf1, j > 4);
         end
      end
      void'(acc_ch.pop_back());
      void'(acc_ch.pop_back());
      void'(acc_b.pop_back());
      void'(acc_b.pop_back());
      repeat (300) tick();
      build_exp();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rxq[k].size() != expq[k].size()) begin
            n_fail++;
            $display("FAIL ovf_count[%0d]: got %0d frames want %0d", k, rxq[k].size(), expq[k].size());
         end
         for (int i = 0; i < expq[k].size(); i++) begin
            n_cmp++;
            if (i >= rxq[k].size() || rxq[k][i] != expq[k][i]) begin
               n_fail++;
               $display("FAIL ovf_frame[%0d][%0d]: got %0h want %0h", k, i, i < rxq[k].size() ? rxq[k][i] : -1, expq[k][i]);
            end
         end
      end
   endtask

   task automatic test_trap();
      int dat[2] = '{-1, -1};
      do_reset();
      release_hold();
      strobe(2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom), 1'b0);
      strobe(2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom), 1'b0);
      strobe(2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom), 1'b1);
      n_cmp++;
      if ({trp0, trp1, done0, done1} !== 4'b1100) begin
         n_fail++;
         $display("FAIL trap_latch: got trp=%b%b done=%b%b want trp=11 done=00", trp0, trp1, done0, done1);
      end
      strobe(2'b01, 8'hee, 8'hee, 1'b0);
      n_cmp++;
      if ({lvl0, lvl1} !== {3'd2, 3'd2}) begin
         n_fail++;
         $display("FAIL trap_ignore_level: got %0d,%0d want 2,2", lvl0, lvl1);
      end
      for (int t = 0; t < 1000 && (dat[0] < 0 || dat[1] < 0); t++) begin
         tick();
         if (done0 === 1'b1 && dat[0] < 0) dat[0] = cyc;
         if (done1 === 1'b1 && dat[1] < 0) dat[1] = cyc;
      end
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (dat[k] != mon_t0[k] + 10 * CPB + 1) begin
            n_fail++;
            $display("FAIL trap_done_time[%0d]: got cycle %0d want %0d", k, dat[k], mon_t0[k] + 10 * CPB + 1);
         end
      end
      build_exp();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rxq[k].size() != expq[k].size()) begin
            n_fail++;
            $display("FAIL trap_count[%0d]: got %0d frames want %0d", k, rxq[k].size(), expq[k].size());
         end
         for (int i = 0; i < expq[k].size(); i++) begin
            n_cmp++;
            if (i >= rxq[k].size() || rxq[k][i] != expq[k][i]) begin
               n_fail++;
               $display("FAIL trap_frame[%0d][%0d]: got %0h want %0h", k, i, i < rxq[k].size() ? rxq[k][i] : -1, expq[k][i]);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      release_hold();
      for (int b = 0; b < 8; b++) begin
         int n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) begin
            strobe(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
         end
         repeat (350) tick();
      end
      n_cmp++;
      if ({ovf0, ovf1} !== {2{m_ovf}}) begin
         n_fail++;
         $display("FAIL rand_ovf: got %b%b want %b", ovf0, ovf1, m_ovf);
      end
      build_exp();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (rxq[k].size() != expq[k].size()) begin
            n_fail++;
            $display("FAIL rand_count[%0d]: got %0d frames want %0d", k, rxq[k].size(), expq[k].size());
         end
         for (int i = 0; i < expq[k].size(); i++) begin
            n_cmp++;
            if (i >= rxq[k].size() || rxq[k][i] != expq[k][i]) begin
               n_fail++;
               $display("FAIL rand_frame[%0d][%0d]: got %0h want %0h", k, i, i < rxq[k].size() ? rxq[k][i] : -1, expq[k][i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      release_hold();
      strobe(2'b11, 8'h00, 8'h5a, 1'b0);
      tick();
      strobe(2'b10, 8'h00, 8'h77, 1'b1);
      repeat (7) tick();
      n_cmp++;
      if ({tx0, tx1, trp0, lvl0, ovf0} !== {2'b00, 1'b1, 3'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL midframe_pre: got tx=%b%b trp=%b lvl=%0d ovf=%b want tx=00 trp=1 lvl=1 ovf=1", tx0, tx1, trp0, lvl0, ovf0);
      end
      resetn = 1'b0;
      tick();
      n_cmp++;
      if ({core0, tx0, lvl0, ovf0, trp0, done0} !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL midframe_reset0: got %b want 01000000", {core0, tx0, lvl0, ovf0, trp0, done0});
      end
      n_cmp++;
      if ({core1, tx1, lvl1, ovf1, trp1, done1} !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL midframe_reset1: got %b want 01000000", {core1, tx1, lvl1, ovf1, trp1, done1});
      end
   endtask

   initial begin
      resetn = 1'b0;
      ch_byte = '0;
      ch_byte_en = '0;
      trap_i = 1'b0;
      test_reset();
      test_single();
      test_tagging();
      test_simultaneous();
      test_overflow();
      test_trap();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
